seq_div_ctrl: RTL and testbench
===============================

Name: seq_div_ctrl

Overview:
- Sequential unsigned restoring-division controller.
- Owns one external DW-bit subtracter: drives its operands each cycle and consumes its difference.
- Produces one quotient bit per cycle.
- Sits between the MDR front end (start/operands) and the shared subtracter datapath.

Parameters:
DW, 16, operand/result width in bits (matches the package data bus width)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
dividend  input  DW  unsigned dividend, sampled on the accepted start cycle
divisor  input  DW  unsigned divisor, sampled on the accepted start cycle
ready  output  1  controller idle, can accept start
done  output  1  one-cycle pulse: result valid
quotient  output  DW  registered quotient
remainder  output  DW  registered remainder
div_by_zero  output  1  registered error flag for the last operation
sub_a  output  DW  minuend to the external subtracter
sub_b  output  DW  subtrahend to the external subtracter
sub_out  input  DW  difference sub_a - sub_b (mod 2^DW), combinational from sub_a/sub_b

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - state=IDLE, ready=1, done=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - sub_a=0, sub_b=0.
  - Internal R, Q, D, iteration counter=0.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - ready=1; sub_a/sub_b driven 0.
  - start=1: register Q<=dividend, D<=divisor, R<=0; go to LOAD.
- LOAD (1 cycle):
  - ready=0.
  - D==0: div_by_zero<=1, quotient<=all ones, remainder<=dividend register; go to DONE.
  - Otherwise: div_by_zero<=0, counter<=DW-1; go to ITER.
- ITER (exactly DW cycles):
  - Trial value T = {R, Q[DW-1]} (DW+1 bits). Tmsb = R[DW-1].
  - sub_a = T[DW-1:0], sub_b = D.
  - ge = Tmsb | (T[DW-1:0] >= D), using a local comparator.
  - ge=1: R<=sub_out; else R<=T[DW-1:0].
  - Q<={Q[DW-2:0], ge}.
  - Counter decrements; leave ITER after the counter==0 step.
  - On exit: quotient<=new Q, remainder<=new R; go to DONE.
- Subtracter result rule: when Tmsb=1 the modular result sub_out equals the true remainder. This rule is mandatory; no DW+1-bit subtracter is used.
- DONE (1 cycle):
  - done=1, ready=0; go to IDLE.
  - start is ignored in this cycle.
- Latency:
  - Accepted start at edge N gives done=1 in the cycle after edge N+DW+1, i.e. DW+2 cycles after acceptance.
  - Divide-by-zero: done 2 cycles after acceptance.
- Output hold: quotient, remainder and div_by_zero hold their values from DONE until the LOAD/ITER exit of the next operation. They do not clear on start.
- start while ready=0: ignored, no queuing. Operand inputs may change freely while busy.
- Back-to-back: minimum issue interval is DW+3 cycles (IDLE cycle required between operations).
- Reset mid-operation: immediately returns to IDLE with all reset values. No done pulse; the partial result is discarded.
- All outputs except sub_a/sub_b are registered. sub_a/sub_b are combinational from state/R/Q/D.

Test Plan:
- DW=16, dividend=100, divisor=7, start for 1 cycle -> done exactly 18 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0; then dividend=0xFFFF, divisor=0xFFFF -> quotient=1, remainder=0. Checks the Tmsb path at the boundary.
- dividend=5, divisor=9 -> quotient=0, remainder=5. Then dividend=0x8001, divisor=0x8000 -> quotient=1, remainder=1.
- dividend=1234, divisor=0 -> done 2 cycles after acceptance; div_by_zero=1, quotient=0xFFFF, remainder=1234.
- Second start pulsed during ITER and during DONE with different operands -> ignored; the first result is unchanged. The next start is accepted only when ready=1.
- rst_n driven low asynchronously (mid-cycle) at ITER step 5 -> all outputs reach reset values before the next edge, with no done pulse. A following 100/7 still yields 14 r 2.

Source files
------------

// File: rtl/seq_div_ctrl.sv
// Sequential unsigned restoring divider controller: one quotient bit per cycle,
// trial subtraction delegated to an external DW-bit subtracter (sub_a - sub_b -> sub_out).
module seq_div_ctrl #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero,
    output logic [DW-1:0] sub_a,
    output logic [DW-1:0] sub_b,
    input  logic [DW-1:0] sub_out
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] r_reg;
    logic [DW-1:0] q_reg;
    logic [DW-1:0] d_reg;
    logic [CW-1:0] cnt;

    logic [DW-1:0] trial;
    logic          tmsb;
    logic          ge;
    logic [DW-1:0] r_next;
    logic [DW-1:0] q_next;

    // Shift-in of the next dividend bit; tmsb is the bit that falls off the DW-bit trial.
    // With tmsb set the true difference is still below 2^DW, so the modular sub_out is exact.
    always_comb begin
        trial  = {r_reg[DW-2:0], q_reg[DW-1]};
        tmsb   = r_reg[DW-1];
        ge     = tmsb | (trial >= d_reg);
        r_next = ge ? sub_out : trial;
        q_next = {q_reg[DW-2:0], ge};
        sub_a  = (state == ITER) ? trial : '0;
        sub_b  = (state == ITER) ? d_reg : '0;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = (d_reg == '0) ? DONE : ITER;
            ITER:    if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            ready <= (next_state == IDLE);
            done  <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                    end
                end
                LOAD: begin
                    if (d_reg == '0) begin
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                        remainder   <= q_reg;
                    end else begin
                        div_by_zero <= 1'b0;
                        cnt         <= CW'(DW - 1);
                    end
                end
                ITER: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed bench for seq_div_ctrl with a behavioural model of the external subtracter.
module tb_seq_div_ctrl;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          ready;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;
    logic [DW-1:0] sub_a;
    logic [DW-1:0] sub_b;
    logic [DW-1:0] sub_out;

    int checks = 0;
    int errors = 0;
    int lat;

    assign sub_out = sub_a - sub_b;

    seq_div_ctrl #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_out    (sub_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start for exactly one accepting edge; returns #1 after that edge.
    task automatic issue(input logic [DW-1:0] dd, input logic [DW-1:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat_out);
        lat_out = lat0;
        while (done !== 1'b1 && lat_out < 100) begin
            @(posedge clk);
            #1;
            lat_out++;
        end
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] dd, input logic [DW-1:0] dv,
                          input logic [DW-1:0] eq, input logic [DW-1:0] er,
                          input logic edz, input int elat);
        int l;
        check({tag, " ready_before"}, 32'(ready), 32'd1);
        issue(dd, dv);
        wait_done(1, l);
        check({tag, " latency"}, 32'(l), 32'(elat));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        @(posedge clk);
        #1;
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check({tag, " ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst quotient", 32'(quotient), 32'd0);
        check("rst remainder", 32'(remainder), 32'd0);
        check("rst div_by_zero", 32'(div_by_zero), 32'd0);
        check("rst sub_a", 32'(sub_a), 32'd0);
        check("rst sub_b", 32'(sub_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, DW + 2);
        run_op("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, DW + 2);
        run_op("ffff/ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, DW + 2);
        run_op("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, DW + 2);
        run_op("8001/8000", 16'h8001, 16'h8000, 16'd1, 16'd1, 1'b0, DW + 2);
        run_op("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 2);

        // Results from the divide-by-zero must hold across the next start.
        issue(16'd1000, 16'd3);
        check("hold dz at LOAD", 32'(div_by_zero), 32'd1);
        check("hold q at LOAD", 32'(quotient), 32'hFFFF);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("busy ready", 32'(ready), 32'd0);
        check("iter sub_b", 32'(sub_b), 32'd3);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, lat);
        check("ign latency", 32'(lat), 32'(DW + 2));
        check("ign quotient", 32'(quotient), 32'd333);
        check("ign remainder", 32'(remainder), 32'd1);
        dividend = 16'd77;
        divisor  = 16'd0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start in DONE ignored ready", 32'(ready), 32'd1);
        check("start in DONE no pulse", 32'(done), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("start in DONE still idle", 32'(ready), 32'd1);
        check("start in DONE q kept", 32'(quotient), 32'd333);
        check("start in DONE dz kept", 32'(div_by_zero), 32'd0);

        // Asynchronous reset in the middle of ITER step 5.
        issue(16'd100, 16'd7);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("pre-rst busy", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst ready", 32'(ready), 32'd1);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst quotient", 32'(quotient), 32'd0);
        check("mid rst remainder", 32'(remainder), 32'd0);
        check("mid rst sub_a", 32'(sub_a), 32'd0);
        check("mid rst sub_b", 32'(sub_b), 32'd0);
        @(posedge clk);
        #1;
        check("in rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DW + 4) begin
            @(posedge clk);
            #1;
            check("post rst no done", 32'(done), 32'd0);
        end
        run_op("100/7 after rst", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, DW + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
